scan_group_bridge: RTL
======================

Name: scan_group_bridge

Overview:
- Parametrised successor to the fixed group scan-to-memory/register interface. One group's static scan request (wen/ren/addr/wdata) is synchronised into the group clock domain and decoded to one of:
  - a wide SRAM, through lane-sliced writes with a one-word read buffer;
  - NUM_REGS generic control registers;
  - read-only status.
- Adds ready timeout, a decode-error flag and read-buffer hits. Sits between group_mux and the group's SRAM and control-register logic.

Parameters:
- SCAN_DW, 32, scan data width
- SCAN_AW, 20, scan address width
- SRAM_DW, 128, SRAM word width; must be a multiple of SCAN_DW; L = SRAM_DW/SCAN_DW lanes, LB = log2(L)
- SRAM_AW, 8, SRAM word-address width
- NUM_REGS, 4, control registers, at most 128
- REG_DW, 11, control-register width, at most SCAN_DW
- TIMEOUT, 255, maximum cycles to wait for a target ready

Ports:
- clk  in  1  group clock
- rst_n  in  1  synchronous active-low reset
- scan_id  in  1  group selected; requests are ignored when low
- static_wen  in  1  scan write request (level, asynchronous to clk)
- static_ren  in  1  scan read request (level, asynchronous to clk)
- static_addr  in  SCAN_AW  scan address
- static_wdata  in  SCAN_DW  scan write data
- static_rdata  out  SCAN_DW  read result
- static_ready  out  1  transaction complete/idle
- sram_ren  out  1  SRAM read pulse
- sram_wen  out  1  SRAM write pulse
- sram_addr  out  SRAM_AW  SRAM word address
- sram_bweb  out  SRAM_DW  bit-write enable, active low
- sram_wdata  out  SRAM_DW  SRAM write data
- sram_rdata  in  SRAM_DW  SRAM read data
- sram_ready  in  1  SRAM access complete
- reg_ren  out  NUM_REGS  per-register read pulse
- reg_wen  out  NUM_REGS  per-register write pulse
- reg_wdata  out  REG_DW  shared register write data
- reg_rdata  in  NUM_REGS*REG_DW  register read data; register i occupies bits [i*REG_DW +: REG_DW]
- reg_ready  in  NUM_REGS  per-register ready
- status_in  in  SCAN_DW  read-only status word
- err_flag  out  1  sticky error: timeout, decode error or wen/ren collision

Behaviour:
- Reset (rst_n low at a clk edge) returns every output to its reset value; this aborts any in-flight transaction.
  - Reset values: static_rdata=0, static_ready=1, sram_ren=0, sram_wen=0, sram_addr=0, sram_bweb all-1, sram_wdata=0, reg_ren=0, reg_wen=0, reg_wdata=0, err_flag=0.
  - The read buffer is invalidated.
- Synchronisation:
  - scan_id, static_wen and static_ren each pass through a 2-flop synchroniser; synchroniser flops reset to 0.
  - Edge-detect history flops reset to 1, so a request level held high through reset is not re-executed.
  - addr/wdata are sampled in the acceptance cycle; scan holds them stable.
- Accept a request on the synchronised rising edge of wen or ren while synchronised scan_id=1. static_ready drops in the cycle after acceptance.
- wen and ren rising in the same cycle: no access is made, err_flag is set, and static_ready returns 1 after 1 cycle.
- Address decode:
  - static_addr[SCAN_AW-1]=1 selects SRAM space: word address = addr[LB +: SRAM_AW], lane = addr[LB-1:0].
    - Nonzero bits above the word field, static_addr[SCAN_AW-2 : LB+SRAM_AW], are a decode error.
  - static_addr[SCAN_AW-1]=0 selects register space by addr[7:0]:
    - 0..NUM_REGS-1 = control registers
    - 0x80 = status_in
    - 0x81 = {SCAN_DW-1 zeros, err_flag}
    - a write to 0x81 clears err_flag
    - any other index is a decode error
- FSM states: IDLE, SRAM_REQ, SRAM_WAIT, REG_REQ, REG_WAIT, DONE.
  - REQ states drive a 1-cycle ren/wen pulse.
  - WAIT states hold until the target ready=1 or until TIMEOUT cycles have elapsed since the pulse.
  - DONE sets static_ready=1 and returns to IDLE.
- SRAM write:
  - sram_wdata = static_wdata replicated across all lanes.
  - sram_bweb is 0 only on the selected lane's bits.
  - If the buffered word address matches, the buffer's lane is updated with the new data.
- SRAM read:
  - Buffer hit (valid buffer, same word address): no SRAM access; static_rdata = buffered lane; static_ready rises 2 cycles after acceptance.
  - Miss: sram_ren pulse, capture sram_rdata when sram_ready=1, buffer becomes valid, return the selected lane.
- Register access:
  - Write: reg_wdata = static_wdata[REG_DW-1:0], one-hot reg_wen pulse.
  - Read: static_rdata = zero-extended register slice.
  - Status reads (0x80/0x81) complete in 1 cycle with no pulse.
- Timeout: abort the access, set err_flag, static_rdata = 0xDEADBEEF truncated/extended to SCAN_DW, invalidate the buffer, complete normally.
- Decode error: no pulse, err_flag set, static_rdata=0.
- While static_ready=0, new request edges are ignored.

Test Plan:
- SRAM lane write then read (defaults): write 0x12345678 to addr 0x80006 (word 1, lane 2) → sram_wen pulse, sram_addr=1, bweb=0 only on bits[95:64]. Read of the same address misses: sram_ren pulse, static_rdata=0x12345678.
- Read-buffer hit: repeat the read of 0x80006 → no sram_ren, static_ready rises 2 cycles after acceptance. Write 0xAAAA5555 to 0x80005, then read it → served from the buffer, returns 0xAAAA5555.
- Registers: write 0x7FF to addr 0x00003 → reg_wen=4'b1000, reg_wdata=0x7FF. Read with reg_rdata slice 3 = 0x155 → static_rdata=0x00000155.
- Timeout: hold sram_ready=0 on a read → no completion before 255 cycles elapse; static_rdata=0xDEADBEEF, err_flag=1. Read 0x81 → 1; write 0x81 → err_flag=0.
- Errors: register index 0x10, or SRAM address with static_addr[18:10]≠0 → no pulse, err_flag=1. wen and ren rising together → no access, err_flag=1.
- Reset mid-SRAM_WAIT with static_wen held high → all outputs at reset values, static_ready=1, no repeat write after reset release.

Source files
------------

// File: rtl/scan_group_bridge.sv
// Bridges one group's static scan request into the group clock domain and routes it
// to a lane-sliced SRAM (with a one-word read buffer), control registers or status.
module scan_group_bridge #(
  parameter int SCAN_DW  = 32,
  parameter int SCAN_AW  = 20,
  parameter int SRAM_DW  = 128,
  parameter int SRAM_AW  = 8,
  parameter int NUM_REGS = 4,
  parameter int REG_DW   = 11,
  parameter int TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       scan_id,
  input  logic                       static_wen,
  input  logic                       static_ren,
  input  logic [SCAN_AW-1:0]         static_addr,
  input  logic [SCAN_DW-1:0]         static_wdata,
  output logic [SCAN_DW-1:0]         static_rdata,
  output logic                       static_ready,
  output logic                       sram_ren,
  output logic                       sram_wen,
  output logic [SRAM_AW-1:0]         sram_addr,
  output logic [SRAM_DW-1:0]         sram_bweb,
  output logic [SRAM_DW-1:0]         sram_wdata,
  input  logic [SRAM_DW-1:0]         sram_rdata,
  input  logic                       sram_ready,
  output logic [NUM_REGS-1:0]        reg_ren,
  output logic [NUM_REGS-1:0]        reg_wen,
  output logic [REG_DW-1:0]          reg_wdata,
  input  logic [NUM_REGS*REG_DW-1:0] reg_rdata,
  input  logic [NUM_REGS-1:0]        reg_ready,
  input  logic [SCAN_DW-1:0]         status_in,
  output logic                       err_flag
);

  localparam int L   = SRAM_DW / SCAN_DW;
  localparam int LB  = $clog2(L);
  localparam int LBW = (LB > 0) ? LB : 1;
  localparam int RIW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [SCAN_AW-1:0] LOW_MASK = SCAN_AW'((64'd1 << (LB + SRAM_AW)) - 64'd1);
  localparam logic [SCAN_AW-1:0] TOP_MASK = SCAN_AW'(64'd1 << (SCAN_AW - 1));
  localparam logic [SCAN_AW-1:0] HI_MASK  = ~(LOW_MASK | TOP_MASK);
  localparam logic [SCAN_DW-1:0] TIMEOUT_DATA = SCAN_DW'(32'hDEADBEEF);

  typedef enum logic [2:0] {IDLE, SRAM_REQ, SRAM_WAIT, REG_REQ, REG_WAIT, DONE} state_t;

  // Synchronisers and edge-detect history
  logic id_s1_q, id_s2_q, wen_s1_q, wen_s2_q, ren_s1_q, ren_s2_q;
  logic wen_h_q, ren_h_q;
  logic [1:0] warm_q;

  // History is forced high until the synchronisers have refilled after reset, so a
  // level held through reset never looks like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_s1_q  <= 1'b0;
      id_s2_q  <= 1'b0;
      wen_s1_q <= 1'b0;
      wen_s2_q <= 1'b0;
      ren_s1_q <= 1'b0;
      ren_s2_q <= 1'b0;
      wen_h_q  <= 1'b1;
      ren_h_q  <= 1'b1;
      warm_q   <= 2'b00;
    end else begin
      id_s1_q  <= scan_id;
      id_s2_q  <= id_s1_q;
      wen_s1_q <= static_wen;
      wen_s2_q <= wen_s1_q;
      ren_s1_q <= static_ren;
      ren_s2_q <= ren_s1_q;
      wen_h_q  <= wen_s2_q | ~warm_q[1];
      ren_h_q  <= ren_s2_q | ~warm_q[1];
      warm_q   <= {warm_q[0], 1'b1};
    end
  end

  logic wen_rise, ren_rise, accept;
  assign wen_rise = wen_s2_q & ~wen_h_q;
  assign ren_rise = ren_s2_q & ~ren_h_q;
  assign accept   = id_s2_q & (wen_rise | ren_rise);

  // Decode of the live scan address, used only in the acceptance cycle
  logic               is_sram_a, sram_hi_err_a;
  logic [SRAM_AW-1:0] word_a;
  logic [LBW-1:0]     lane_a;
  logic [7:0]         idx_a;
  logic [SRAM_DW-1:0] lane_mask_a;
  logic [NUM_REGS-1:0] onehot_a;

  assign is_sram_a     = static_addr[SCAN_AW-1];
  assign sram_hi_err_a = |(static_addr & HI_MASK);
  assign word_a        = static_addr[LB +: SRAM_AW];
  assign lane_a        = (LB > 0) ? static_addr[LBW-1:0] : '0;
  assign idx_a         = static_addr[7:0];
  assign lane_mask_a   = SRAM_DW'({SCAN_DW{1'b1}}) << (lane_a * SCAN_DW);
  assign onehot_a      = NUM_REGS'(1) << idx_a;

  state_t              state_q, state_d;
  logic [SRAM_AW-1:0]  word_q, word_d;
  logic [LBW-1:0]      lane_q, lane_d;
  logic [RIW-1:0]      sel_q, sel_d;
  logic                wr_q, wr_d;
  logic [SCAN_DW-1:0]  wdata_q, wdata_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic                buf_valid_q, buf_valid_d;
  logic [SRAM_AW-1:0]  buf_addr_q, buf_addr_d;
  logic [SRAM_DW-1:0]  buf_data_q, buf_data_d;
  logic [SCAN_DW-1:0]  rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                sram_ren_q, sram_ren_d, sram_wen_q, sram_wen_d;
  logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
  logic [SRAM_DW-1:0]  sram_bweb_q, sram_bweb_d, sram_wdata_q, sram_wdata_d;
  logic [NUM_REGS-1:0] reg_ren_q, reg_ren_d, reg_wen_q, reg_wen_d;
  logic [REG_DW-1:0]   reg_wdata_q, reg_wdata_d;
  logic                err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_q       <= '0;
      lane_q       <= '0;
      sel_q        <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      rdata_q      <= '0;
      ready_q      <= 1'b1;
      sram_ren_q   <= 1'b0;
      sram_wen_q   <= 1'b0;
      sram_addr_q  <= '0;
      sram_bweb_q  <= '1;
      sram_wdata_q <= '0;
      reg_ren_q    <= '0;
      reg_wen_q    <= '0;
      reg_wdata_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      lane_q       <= lane_d;
      sel_q        <= sel_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      buf_valid_q  <= buf_valid_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
      sram_ren_q   <= sram_ren_d;
      sram_wen_q   <= sram_wen_d;
      sram_addr_q  <= sram_addr_d;
      sram_bweb_q  <= sram_bweb_d;
      sram_wdata_q <= sram_wdata_d;
      reg_ren_q    <= reg_ren_d;
      reg_wen_q    <= reg_wen_d;
      reg_wdata_q  <= reg_wdata_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    lane_d       = lane_q;
    sel_d        = sel_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    buf_valid_d  = buf_valid_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    rdata_d      = rdata_q;
    ready_d      = ready_q;
    sram_ren_d   = 1'b0;
    sram_wen_d   = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_bweb_d  = '1;
    sram_wdata_d = sram_wdata_q;
    reg_ren_d    = '0;
    reg_wen_d    = '0;
    reg_wdata_d  = reg_wdata_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          ready_d = 1'b0;
          wr_d    = wen_rise;
          wdata_d = static_wdata;
          word_d  = word_a;
          lane_d  = lane_a;
          sel_d   = RIW'(idx_a);
          state_d = DONE;
          if (wen_rise && ren_rise) begin
            err_d = 1'b1;
          end else if (is_sram_a) begin
            if (sram_hi_err_a) begin
              err_d   = 1'b1;
              rdata_d = '0;
            end else if (wen_rise) begin
              sram_wen_d   = 1'b1;
              sram_addr_d  = word_a;
              sram_bweb_d  = ~lane_mask_a;
              sram_wdata_d = {L{static_wdata}};
              state_d      = SRAM_REQ;
            end else if (buf_valid_q && buf_addr_q == word_a) begin
              rdata_d = buf_data_q[lane_a*SCAN_DW +: SCAN_DW];
            end else begin
              sram_ren_d  = 1'b1;
              sram_addr_d = word_a;
              state_d     = SRAM_REQ;
            end
          end else if (int'(idx_a) < NUM_REGS) begin
            if (wen_rise) begin
              reg_wen_d   = onehot_a;
              reg_wdata_d = static_wdata[REG_DW-1:0];
            end else begin
              reg_ren_d = onehot_a;
            end
            state_d = REG_REQ;
          end else if (idx_a == 8'h80) begin
            if (!wen_rise) rdata_d = status_in;
          end else if (idx_a == 8'h81) begin
            if (wen_rise) err_d = 1'b0;
            else          rdata_d = {{(SCAN_DW-1){1'b0}}, err_q};
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      SRAM_REQ: begin
        cnt_d   = '0;
        state_d = SRAM_WAIT;
      end
      SRAM_WAIT: begin
        if (sram_ready) begin
          state_d = DONE;
          if (wr_q) begin
            // Keep the buffered word coherent with the lane just written
            if (buf_valid_q && buf_addr_q == word_q)
              buf_data_d[lane_q*SCAN_DW +: SCAN_DW] = wdata_q;
          end else begin
            buf_valid_d = 1'b1;
            buf_addr_d  = word_q;
            buf_data_d  = sram_rdata;
            rdata_d     = sram_rdata[lane_q*SCAN_DW +: SCAN_DW];
          end
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          state_d     = DONE;
          err_d       = 1'b1;
          rdata_d     = TIMEOUT_DATA;
          buf_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REG_REQ: begin
        cnt_d   = '0;
        state_d = REG_WAIT;
      end
      REG_WAIT: begin
        if (reg_ready[sel_q]) begin
          state_d = DONE;
          if (!wr_q) rdata_d = SCAN_DW'(reg_rdata[sel_q*REG_DW +: REG_DW]);
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          state_d     = DONE;
          err_d       = 1'b1;
          rdata_d     = TIMEOUT_DATA;
          buf_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign static_rdata = rdata_q;
  assign static_ready = ready_q;
  assign sram_ren     = sram_ren_q;
  assign sram_wen     = sram_wen_q;
  assign sram_addr    = sram_addr_q;
  assign sram_bweb    = sram_bweb_q;
  assign sram_wdata   = sram_wdata_q;
  assign reg_ren      = reg_ren_q;
  assign reg_wen      = reg_wen_q;
  assign reg_wdata    = reg_wdata_q;
  assign err_flag     = err_q;

endmodule
